// File: rtl/neuron_pkg.sv
// Shared constants and state encoding for the serial sonar-classifier neuron.
// The split accumulator and the sequencer top both import this package.
package neuron_pkg;

  localparam int BROJ_ULAZA = 60;
  localparam int DATA_W     = 16;
  localparam int SUM_W      = 22;
  localparam int ADDR_W     = 6;
  localparam int SIGN_BIT   = 15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCUM   = 3'd1,
    COMPARE = 3'd2,
    LOOKUP  = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/neuron_serial_sequencer_split_accumulator.sv
// Separate positive/negative product accumulators and the |P-N| / sign resolver
// that feeds the sigmoid lookup.
module split_accumulator
  import neuron_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic              negative,
  input  logic [DATA_W-1:0] product,
  input  logic              resolve,
  output logic [SUM_W-1:0]  magnitude,
  output logic              sign
);

  logic [SUM_W-1:0] p_suma;
  logic [SUM_W-1:0] n_suma;
  logic [SUM_W-1:0] product_ext;

  assign product_ext = {{(SUM_W-DATA_W){1'b0}}, product};

  // Route each accepted product into the accumulator chosen by the weight sign.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_suma <= {SUM_W{1'b0}};
      n_suma <= {SUM_W{1'b0}};
    end else if (clear) begin
      p_suma <= {SUM_W{1'b0}};
      n_suma <= {SUM_W{1'b0}};
    end else if (enable) begin
      if (negative) begin
        n_suma <= n_suma + product_ext;
      end else begin
        p_suma <= p_suma + product_ext;
      end
    end
  end

  // Equal sums resolve to the negative side, so a zero result carries sign 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      magnitude <= {SUM_W{1'b0}};
      sign      <= 1'b0;
    end else if (resolve) begin
      if (p_suma > n_suma) begin
        magnitude <= p_suma - n_suma;
        sign      <= 1'b0;
      end else begin
        magnitude <= n_suma - p_suma;
        sign      <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/neuron_serial_sequencer.sv
// One-multiplier neuron sequencer: streams 60 feature/weight pairs through a
// shared multiplier, resolves the signed sum and captures the sigmoid output.
module neuron_serial_sequencer
  import neuron_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] feature_in,
  input  logic              feature_valid,
  output logic              feature_ready,
  output logic [ADDR_W-1:0] weight_addr,
  input  logic [DATA_W-1:0] weight_data,
  output logic [DATA_W-1:0] mul_weight,
  output logic [DATA_W-1:0] mul_sample,
  input  logic [DATA_W-1:0] mul_product,
  output logic [SUM_W-1:0]  sig_suma,
  output logic              sig_predznak,
  input  logic [DATA_W-1:0] sig_vjerojatnost,
  output logic [DATA_W-1:0] izlaz,
  output logic              done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BROJ_ULAZA - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] count;
  logic              accept;
  logic              acc_clear;

  assign accept      = feature_ready & feature_valid;
  assign weight_addr = count;
  assign mul_weight  = weight_data;
  assign mul_sample  = feature_in;

  // Next-state decode; start is only looked at while idle.
  always_comb begin
    state_next = state;
    acc_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ACCUM;
          acc_clear  = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      ACCUM: begin
        if (accept && (count == LAST_IDX)) begin
          state_next = COMPARE;
        end else begin
          state_next = ACCUM;
        end
      end
      COMPARE: state_next = LOOKUP;
      LOOKUP:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and status flags, registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      feature_ready <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_next;
      feature_ready <= (state_next == ACCUM);
      busy          <= (state_next != IDLE);
      done          <= (state_next == DONE);
    end
  end

  // Feature counter doubles as the weight ROM address.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {ADDR_W{1'b0}};
    end else if (acc_clear) begin
      count <= {ADDR_W{1'b0}};
    end else if (accept) begin
      count <= count + ADDR_W'(1);
    end
  end

  // The neuron output holds between lookups.
  always_ff @(posedge clk) begin
    if (rst) begin
      izlaz <= {DATA_W{1'b0}};
    end else if (state == LOOKUP) begin
      izlaz <= sig_vjerojatnost;
    end
  end

  split_accumulator u_acc (
    .clk       (clk),
    .rst       (rst),
    .clear     (acc_clear),
    .enable    (accept),
    .negative  (weight_data[SIGN_BIT]),
    .product   (mul_product),
    .resolve   (state == COMPARE),
    .magnitude (sig_suma),
    .sign      (sig_predznak)
  );

endmodule

// File: tb/tb_neuron_serial_sequencer.sv
// Directed bench for neuron_serial_sequencer with a behavioural weight ROM,
// a constant multiplier stub and a simple sigmoid table stand-in.
module tb_neuron_serial_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] feature_in = 16'd0;
  logic        feature_valid = 1'b0;
  logic        feature_ready;
  logic [5:0]  weight_addr;
  logic [15:0] weight_data;
  logic [15:0] mul_weight;
  logic [15:0] mul_sample;
  logic [15:0] mul_product;
  logic [21:0] sig_suma;
  logic        sig_predznak;
  logic [15:0] sig_vjerojatnost;
  logic [15:0] izlaz;
  logic        done;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  int          rom_mode = 0;
  logic [15:0] prod_val = 16'd100;
  logic        zero_features = 1'b0;

  int n_acc, addr_err, wire_err, lat, total;

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [5:0] a);
    if (rom_mode == 1) return 16'h0001 + {10'd0, a};
    if (a < 6'd24) return 16'h0100 + {10'd0, a};
    return 16'h8000 | {10'd0, a};
  endfunction

  function automatic logic [15:0] lut(input logic [21:0] s, input logic p);
    return {p, s[14:0]} ^ 16'h5A5A;
  endfunction

  assign weight_data      = rom(weight_addr);
  assign mul_product      = prod_val;
  assign sig_vjerojatnost = lut(sig_suma, sig_predznak);

  neuron_serial_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .feature_in(feature_in), .feature_valid(feature_valid), .feature_ready(feature_ready),
    .weight_addr(weight_addr), .weight_data(weight_data),
    .mul_weight(mul_weight), .mul_sample(mul_sample), .mul_product(mul_product),
    .sig_suma(sig_suma), .sig_predznak(sig_predznak), .sig_vjerojatnost(sig_vjerojatnost),
    .izlaz(izlaz), .done(done), .busy(busy)
  );

  // Drives one inference: start pulse, then features until stop_after accepts.
  // gaps=1 toggles valid every cycle; start_at re-pulses start mid-stream.
  task automatic run(input int stop_after, input bit gaps, input int start_at);
    int cyc;
    n_acc = 0; addr_err = 0; wire_err = 0; lat = 0; cyc = 0;
    @(negedge clk);
    start = 1'b1;
    while (n_acc < stop_after && cyc < 400) begin
      @(negedge clk);
      start         = (cyc == start_at);
      feature_valid = gaps ? ~cyc[0] : 1'b1;
      feature_in    = zero_features ? 16'd0 : 16'(cyc + 7);
      #1;
      if (feature_valid && feature_ready) begin
        if (weight_addr !== 6'(n_acc)) addr_err++;
        if (mul_sample !== feature_in || mul_weight !== weight_data) wire_err++;
        n_acc++;
      end
      cyc++;
    end
    total = cyc;
    if (stop_after >= 60) begin
      while (done !== 1'b1 && lat < 20) begin
        @(negedge clk);
        feature_valid = 1'b0;
        start         = 1'b0;
        lat++;
      end
      total = total + lat;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy, done, feature_ready, sig_predznak} !== 4'b0000 || sig_suma !== 22'd0 || izlaz !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset: busy=%b done=%b ready=%b suma=%0d pred=%b izlaz=%h, expected all zero",
               busy, done, feature_ready, sig_suma, sig_predznak, izlaz);
    end
    rst = 1'b0;
  endtask

  task automatic test_mixed();
    rom_mode = 0; prod_val = 16'd100; zero_features = 1'b0;
    run(60, 1'b0, -1);
    tests_run++;
    if (sig_suma !== 22'd1200 || sig_predznak !== 1'b1) begin
      tests_failed++;
      $display("FAIL mixed_sum: suma=%0d pred=%b, expected 1200/1", sig_suma, sig_predznak);
    end
    tests_run++;
    if (izlaz !== lut(22'd1200, 1'b1)) begin
      tests_failed++;
      $display("FAIL mixed_izlaz: got %h expected %h", izlaz, lut(22'd1200, 1'b1));
    end
    tests_run++;
    if (total !== 63 || lat !== 3 || addr_err !== 0 || wire_err !== 0) begin
      tests_failed++;
      $display("FAIL mixed_timing: total=%0d lat=%0d addr_err=%0d wire_err=%0d, expected 63/3/0/0",
               total, lat, addr_err, wire_err);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || izlaz !== lut(22'd1200, 1'b1)) begin
      tests_failed++;
      $display("FAIL mixed_after: done=%b busy=%b izlaz=%h, expected 0/0/%h",
               done, busy, izlaz, lut(22'd1200, 1'b1));
    end
  endtask

  task automatic test_all_positive();
    rom_mode = 1; prod_val = 16'hFFFF;
    run(60, 1'b0, -1);
    tests_run++;
    if (sig_suma !== 22'h3BFFC4 || sig_predznak !== 1'b0 || izlaz !== lut(22'h3BFFC4, 1'b0)) begin
      tests_failed++;
      $display("FAIL all_positive: suma=%h pred=%b izlaz=%h, expected 3bffc4/0/%h",
               sig_suma, sig_predznak, izlaz, lut(22'h3BFFC4, 1'b0));
    end
  endtask

  task automatic test_zero_features();
    rom_mode = 0; prod_val = 16'd0; zero_features = 1'b1;
    run(60, 1'b0, -1);
    tests_run++;
    if (sig_suma !== 22'd0 || sig_predznak !== 1'b1 || izlaz !== 16'hDA5A) begin
      tests_failed++;
      $display("FAIL zero_features: suma=%0d pred=%b izlaz=%h, expected 0/1/da5a",
               sig_suma, sig_predznak, izlaz);
    end
    zero_features = 1'b0;
  endtask

  task automatic test_valid_gaps();
    rom_mode = 0; prod_val = 16'd100;
    run(60, 1'b1, -1);
    tests_run++;
    if (n_acc !== 60 || addr_err !== 0 || lat !== 3) begin
      tests_failed++;
      $display("FAIL valid_gaps: accepts=%0d addr_err=%0d lat=%0d, expected 60/0/3", n_acc, addr_err, lat);
    end
    tests_run++;
    if (sig_suma !== 22'd1200 || sig_predznak !== 1'b1) begin
      tests_failed++;
      $display("FAIL valid_gaps_sum: suma=%0d pred=%b, expected 1200/1", sig_suma, sig_predznak);
    end
  endtask

  task automatic test_start_ignored();
    rom_mode = 0; prod_val = 16'd100;
    run(60, 1'b0, 20);
    tests_run++;
    if (sig_suma !== 22'd1200 || sig_predznak !== 1'b1 || total !== 63 || addr_err !== 0) begin
      tests_failed++;
      $display("FAIL start_in_accum: suma=%0d pred=%b total=%0d addr_err=%0d, expected 1200/1/63/0",
               sig_suma, sig_predznak, total, addr_err);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || feature_ready !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_in_done: busy=%b ready=%b done=%b, expected 0/0/0", busy, feature_ready, done);
    end
  endtask

  task automatic test_reset_mid_accum();
    rom_mode = 0; prod_val = 16'd100;
    run(30, 1'b0, -1);
    feature_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || feature_ready !== 1'b0 || izlaz !== 16'd0 || sig_suma !== 22'd0 || sig_predznak !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_accum: busy=%b ready=%b izlaz=%h suma=%0d pred=%b, expected all zero",
               busy, feature_ready, izlaz, sig_suma, sig_predznak);
    end
    rst = 1'b0;
    run(60, 1'b0, -1);
    tests_run++;
    if (sig_suma !== 22'd1200 || sig_predznak !== 1'b1 || total !== 63) begin
      tests_failed++;
      $display("FAIL rerun_after_reset: suma=%0d pred=%b total=%0d, expected 1200/1/63",
               sig_suma, sig_predznak, total);
    end
  endtask

  initial begin
    test_reset();
    test_mixed();
    test_all_positive();
    test_zero_features();
    test_valid_gaps();
    test_start_ignored();
    test_reset_mid_accum();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
